seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Multi-cycle shift-add multiplier that sits directly upstream of the ALU result-select mux bank.
- RES drives the multiply input of the 8-way result selector.
- PRODUCT exposes the full double-width result for the HI/LO path.
- Uses a START/DONE handshake so the ALU controller holds the mux select until DONE.

Parameters:
- WIDTH, 32, operand width in bits; PRODUCT is 2*WIDTH.

Ports:
- CLK  input  1  single clock, rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  multiplicand; captured on the accepting edge.
- B  input  WIDTH  multiplier; captured on the accepting edge.
- BUSY  output  1  high in CALC and DONE states.
- DONE  output  1  one-cycle pulse; PRODUCT valid.
- PRODUCT  output  2*WIDTH  registered full product.
- RES  output  WIDTH  PRODUCT[WIDTH-1:0], fed to the mux input.

Behaviour:
- Reset (RST_N low, async): state=IDLE, BUSY=0, DONE=0, PRODUCT=0, RES=0, internal count=0, operand registers=0.
- FSM states:
  - IDLE: START=1 at an edge loads mcand=A, mplier=B, acc=0, count=0, then goes to CALC. START=0 stays in IDLE.
  - CALC: one bit per edge. If mplier[0]=1, acc += mcand, computed in a (WIDTH+1)-bit sum so the carry is kept. Then {acc,mplier} shifts right by 1 and count increments. When count reaches WIDTH-1 on an edge, that edge is the last iteration and the next state is DONE.
  - DONE: PRODUCT={acc,mplier} is registered and DONE=1 for exactly one cycle. Next state is IDLE unconditionally.
- Latency: START accepted at edge 0; DONE high during the cycle after edge WIDTH+1 (33 edges for WIDTH=32). No back-to-back acceptance before IDLE is re-entered.
- START while BUSY=1 (CALC or DONE) is ignored; there is no queueing. A and B changes after acceptance have no effect.
- PRODUCT/RES hold their last value from DONE until the next DONE; they are not cleared on a new START.
- Reset mid-operation aborts immediately to the reset values; no DONE is emitted.
- Arithmetic is unsigned by default. Overflow is impossible because the product fits in 2*WIDTH bits.
- Operand 0 still runs all WIDTH iterations; there is no early termination.

Optional Feature:
- Macro: SEQ_MULTIPLIER_SIGNED_EN.
- Defined: A and B are two's complement.
  - On acceptance, the magnitudes |A| and |B| are loaded and sign = A[MSB]^B[MSB] is registered.
  - In DONE, PRODUCT is the two's-complement negation of the unsigned result when sign=1.
  - Latency is unchanged.
  - The most-negative operand is handled by its magnitude 2^(WIDTH-1) in the WIDTH-bit unsigned register.
- Undefined: purely unsigned; no sign register is present.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: ST_IDLE=2'b00, ST_CALC=2'b01, ST_DONE=2'b10;
  - a count-width constant, $clog2(WIDTH);
  - the ALU select code assigned to multiply (3'b101) so the controller and the mux bank agree.
- One sub-module is natural: mul_datapath. It contains the acc/mplier/mcand registers, the (WIDTH+1)-bit adder and the shifter, and is controlled by load/step strobes from the FSM in seq_multiplier.

Test Plan:
- Basic multiply: A=3, B=5, START pulse → DONE pulses exactly 33 edges later; PRODUCT=64'd15, RES=32'd15, BUSY high for 33 cycles.
- Maximum operands: A=32'hFFFFFFFF, B=32'hFFFFFFFF → PRODUCT=64'hFFFFFFFE00000001, RES=32'h00000001.
- START while busy: START re-asserted at cycle 10 with A=7, B=7 → ignored; result is still 15 from the original A=3, B=5; the next START in IDLE is accepted.
- Reset mid-operation: RST_N low at cycle 12 → BUSY, DONE and PRODUCT go to 0 asynchronously (before the next edge); no DONE afterwards; a fresh A=2, B=9 gives 18.
- Zero operand: A=0, B=32'h12345678 → full 33-cycle latency, PRODUCT=0.
- Signed mode (SEQ_MULTIPLIER_SIGNED_EN defined):
  - A=-3 (32'hFFFFFFFD), B=5 → PRODUCT=64'hFFFFFFFFFFFFFFF1;
  - A=32'h80000000, B=-1 → PRODUCT=64'h0000000080000000.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared constants for the sequential shift-add multiplier and its
// neighbours (ALU controller, result-select mux bank).
package seq_multiplier_pkg;

  // Default operand width used by the ALU slice.
  localparam int WIDTH_DEF = 32;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_CALC = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  // Iteration counter width for the default operand width.
  localparam int CNT_W = $clog2(WIDTH_DEF);

  // Result-select code of the multiply input in the 8-way ALU mux bank.
  localparam logic [2:0] ALU_SEL_MUL = 3'b101;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_if.sv
// START/DONE handshake and result bus between the ALU controller (master)
// and the sequential multiplier (slave).
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();

  logic                 START;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 BUSY;
  logic                 DONE;
  logic [2*WIDTH-1:0]   PRODUCT;
  logic [WIDTH-1:0]     RES;

  modport master (
    output START, A, B,
    input  BUSY, DONE, PRODUCT, RES
  );

  modport slave (
    input  START, A, B,
    output BUSY, DONE, PRODUCT, RES
  );

endinterface : seq_multiplier_if

// File: rtl/seq_multiplier_mul_datapath.sv
// Shift-add datapath: multiplicand / multiplier / accumulator registers,
// the (WIDTH+1)-bit adder that keeps the carry, and the right shifter.
// With SEQ_MULTIPLIER_SIGNED_EN defined, operand magnitudes are loaded and
// the result sign is reapplied on the combinational result output.
module mul_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   result_o
);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   mcand_ld_s;
  logic [WIDTH-1:0]   mplier_ld_s;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic               sign_q;
  logic               sign_ld_s;
  logic [2*WIDTH-1:0] raw_s;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Operand values loaded on acceptance: magnitudes plus product sign.
  always_comb begin
    mcand_ld_s  = magnitude(a_i);
    mplier_ld_s = magnitude(b_i);
    sign_ld_s   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
  end

  // Reapply the sign to the unsigned shift-add result.
  always_comb begin
    raw_s = {acc_q, mplier_q};
    if (sign_q) begin
      result_o = ~raw_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_o = raw_s;
    end
  end
`else
  // Operands are loaded unchanged in unsigned mode.
  always_comb begin
    mcand_ld_s  = a_i;
    mplier_ld_s = b_i;
  end

  // Result is the concatenated accumulator and shifted multiplier.
  always_comb begin
    result_o = {acc_q, mplier_q};
  end
`endif

  // Conditional add of the multiplicand, carry kept in the top bit.
  always_comb begin
    if (mplier_q[0]) begin
      sum_s = {1'b0, acc_q} + {1'b0, mcand_q};
    end else begin
      sum_s = {1'b0, acc_q};
    end
  end

  // Operand load on acceptance, one add-and-shift per step strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else if (load_i) begin
      mcand_q  <= mcand_ld_s;
      mplier_q <= mplier_ld_s;
      acc_q    <= {WIDTH{1'b0}};
`ifdef SEQ_MULTIPLIER_SIGNED_EN
      sign_q   <= sign_ld_s;
`endif
    end else if (step_i) begin
      acc_q    <= sum_s[WIDTH:1];
      mplier_q <= {sum_s[0], mplier_q[WIDTH-1:1]};
    end
  end

endmodule : mul_datapath

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier feeding the ALU result-select mux.
// START is accepted only in IDLE; DONE pulses for one cycle 33 edges later
// (WIDTH=32) with PRODUCT/RES registered and held until the next DONE.
// Optional build macro: SEQ_MULTIPLIER_SIGNED_EN (two's-complement operands).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RST_N,
  seq_multiplier_if.slave     bus
);

  localparam int CNT_BITS = $clog2(WIDTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_BITS-1:0]  count_q;
  logic                 load_s;
  logic                 step_s;
  logic                 prod_ld_s;
  logic                 busy_d;
  logic                 done_d;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;
  logic [2*WIDTH-1:0]   result_s;

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load_i   (load_s),
    .step_i   (step_s),
    .a_i      (bus.A),
    .b_i      (bus.B),
    .result_o (result_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, WIDTH steps in CALC, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (count_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/strobe decode for the datapath and the registered handshake.
  always_comb begin
    load_s    = 1'b0;
    step_s    = 1'b0;
    prod_ld_s = 1'b0;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          load_s = 1'b1;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_CALC: begin
        step_s = 1'b1;
        busy_d = 1'b1;
      end
      ST_DONE: begin
        prod_ld_s = 1'b1;
        done_d    = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Iteration counter: cleared on acceptance, advanced on every step.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= {CNT_BITS{1'b0}};
    end else if (load_s) begin
      count_q <= {CNT_BITS{1'b0}};
    end else if (step_s) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  // Registered handshake and product; product holds between DONE pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (prod_ld_s) begin
        product_q <= result_s;
      end
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.PRODUCT = product_q;
  assign bus.RES     = product_q[WIDTH-1:0];

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Directed scoreboard bench for seq_multiplier (WIDTH=32).
module tb_seq_multiplier;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  seq_multiplier_if #(.WIDTH(W)) bus ();

  seq_multiplier #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // Edge counter used for latency measurement.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc = 0;
  logic [63:0] last_exp = 64'd0;

  // Independent reference product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    return ax * bx;
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with START for one edge; optionally push the expectation.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.A = a;
    bus.B = b;
    if (push) exp_q.push_back(ref_mul(a, b));
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    bus.START = 1'b0;
  endtask

  // Bounded wait for DONE, then scoreboard compare and pulse/hold checks.
  task automatic wait_done(input string tag, input bit chk_busy);
    int guard;
    int busy_n;
    logic [63:0] e;
    guard = 0;
    busy_n = 0;
    while (bus.DONE !== 1'b1 && guard < 200) begin
      if (bus.BUSY === 1'b1) busy_n++;
      @(posedge CLK);
      #1;
      guard++;
    end
    check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd33);
    if (chk_busy) check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 64'hDEAD_BEEF_DEAD_BEEF;
    last_exp = e;
    check({tag, "_product"}, bus.PRODUCT, e);
    check({tag, "_res"}, 64'(bus.RES), {32'd0, e[31:0]});
    check({tag, "_busy_at_done"}, 64'(bus.BUSY), 64'd0);
    @(posedge CLK);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.DONE), 64'd0);
    check({tag, "_hold"}, bus.PRODUCT, e);
  endtask

  initial begin
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.START = 1'b0;
    bus.A = 32'd0;
    bus.B = 32'd0;

    // Reset values.
    #1;
    check("rst_busy", 64'(bus.BUSY), 64'd0);
    check("rst_done", 64'(bus.DONE), 64'd0);
    check("rst_product", bus.PRODUCT, 64'd0);
    check("rst_res", 64'(bus.RES), 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // Basic multiply.
    start_op(32'd3, 32'd5, 1'b1);
    wait_done("basic", 1'b1);

    // Maximum operands.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done("max", 1'b1);
`ifndef SEQ_MULTIPLIER_SIGNED_EN
    check("max_const", bus.PRODUCT, 64'hFFFF_FFFE_0000_0001);
`endif

    // START while busy is ignored; product holds until the next DONE.
    start_op(32'd3, 32'd5, 1'b1);
    repeat (9) @(posedge CLK);
    #1;
    check("busy_prod_hold", bus.PRODUCT, last_exp);
    @(negedge CLK);
    bus.START = 1'b1;
    bus.A = 32'd7;
    bus.B = 32'd7;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    check("busy_still", 64'(bus.BUSY), 64'd1);
    wait_done("busy_ign", 1'b0);
    check("busy_ign_const", bus.PRODUCT, 64'd15);
    start_op(32'd7, 32'd7, 1'b1);
    wait_done("after_busy", 1'b0);

    // Asynchronous reset mid-operation.
    start_op(32'd3, 32'd5, 1'b0);
    repeat (11) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_busy", 64'(bus.BUSY), 64'd0);
    check("arst_done", 64'(bus.DONE), 64'd0);
    check("arst_product", bus.PRODUCT, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (bus.DONE === 1'b1) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'd0);
    check("arst_idle", 64'(bus.BUSY), 64'd0);
    start_op(32'd2, 32'd9, 1'b1);
    wait_done("post_rst", 1'b0);
    check("post_rst_const", bus.PRODUCT, 64'd18);

    // Zero operand still takes full latency.
    start_op(32'd0, 32'h1234_5678, 1'b1);
    wait_done("zero", 1'b1);
    check("zero_const", bus.PRODUCT, 64'd0);

    // A few random operand pairs.
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      start_op(ra, rb, 1'b1);
      wait_done("rand", 1'b0);
    end

    // Signed-mode reference cases.
    start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done("neg3x5", 1'b0);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    check("neg3x5_const", bus.PRODUCT, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("neg3x5_const", bus.PRODUCT, 64'h0000_0004_FFFF_FFF1);
`endif
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("minxneg1", 1'b0);
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    check("minxneg1_const", bus.PRODUCT, 64'h0000_0000_8000_0000);
`else
    check("minxneg1_const", bus.PRODUCT, 64'h7FFF_FFFF_8000_0000);
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_multiplier
